// File: rtl/mc_control.sv
// Multi-cycle MIPS-style control unit: one state per microstep, bounded memory waits,
// and a saturating count of retired instructions.
module mc_control #(
    parameter int ALUOP_W     = 3,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         instr_op_i,
    input  logic [5:0]         funct_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic [1:0]         pc_src_o,
    output logic               ir_write_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               iord_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               reg_write_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic [3:0]         state_o,
    output logic               illegal_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   instr_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_ADDI = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_SLTI = ALUOP_W'(3'b100);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12
    } state_t;

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [CNT_W-1:0]    instr_cnt;
    logic                waiting, expired, retire;

    assign waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign expired = waiting && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (retire && !(&instr_cnt))
                instr_cnt <= instr_cnt + 1'b1;
        end
    end

    // The counter only advances while parked in the same waiting state; any move clears it.
    assign wait_nxt = (waiting && !expired && state_nxt == state) ? wait_cnt + 1'b1 : '0;

    always_comb begin
        state_nxt    = state;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'b00;
        ir_write_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = ALU_ADD;
        reg_write_o  = 1'b0;
        reg_dst_o    = 2'b00;
        mem_to_reg_o = 2'b00;
        illegal_o    = 1'b0;
        timeout_o    = 1'b0;
        retire       = 1'b0;
        if (expired) begin
            // Abort silently: no strobes, no writes, ready is not consulted.
            timeout_o = 1'b1;
            state_nxt = S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    if (mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                        state_nxt  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b_o = 2'b11;
                    case (instr_op_i)
                        6'd0:         state_nxt = (funct_i == 6'b001000) ? S_JR : S_EXEC_R;
                        6'd4:         state_nxt = S_BRANCH;
                        6'd8, 6'd10:  state_nxt = S_EXEC_I;
                        6'd35, 6'd43: state_nxt = S_MEM_ADDR;
                        6'd2, 6'd3:   state_nxt = S_JUMP;
                        default: begin
                            illegal_o = 1'b1;
                            state_nxt = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    state_nxt   = (instr_op_i == 6'd35) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                    if (mem_ready_i) state_nxt = S_MEM_WB;
                end
                S_MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 2'b01;
                    state_nxt    = S_FETCH;
                    retire       = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write_o = 1'b1;
                    iord_o      = 1'b1;
                    if (mem_ready_i) begin
                        state_nxt = S_FETCH;
                        retire    = 1'b1;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_FUNC;
                    state_nxt   = S_WB_R;
                end
                S_WB_R: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = 2'b01;
                    state_nxt   = S_FETCH;
                    retire      = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    alu_op_o    = (instr_op_i == 6'd10) ? ALU_SLTI : ALU_ADDI;
                    state_nxt   = S_WB_I;
                end
                S_WB_I: begin
                    reg_write_o = 1'b1;
                    state_nxt   = S_FETCH;
                    retire      = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_SUB;
                    pc_src_o    = 2'b01;
                    pc_write_o  = zero_i;
                    state_nxt   = S_FETCH;
                    retire      = 1'b1;
                end
                S_JUMP: begin
                    pc_write_o = 1'b1;
                    pc_src_o   = 2'b10;
                    if (instr_op_i == 6'd3) begin
                        reg_write_o  = 1'b1;
                        reg_dst_o    = 2'b10;
                        mem_to_reg_o = 2'b10;
                    end
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end
                S_JR: begin
                    pc_write_o = 1'b1;
                    pc_src_o   = 2'b11;
                    state_nxt  = S_FETCH;
                    retire     = 1'b1;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    assign state_o     = state;
    assign instr_cnt_o = instr_cnt;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: directed instruction walks with literal expectations, then
// randomized traffic checked every cycle against a state-table reference model.
module tb_mc_control;

    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic       zero = 1'b0, ready = 1'b0;

    logic       pc_write, ir_write, mem_read, mem_write, iord, alu_a, reg_write, illegal, timeout;
    logic [1:0] pc_src, alu_b, reg_dst, mem_to_reg;
    logic [2:0] alu_op;
    logic [3:0] state, icnt;

    mc_control #(.ALUOP_W(3), .CNT_W(4), .MEM_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .instr_op_i(op), .funct_i(funct), .zero_i(zero),
        .mem_ready_i(ready), .pc_write_o(pc_write), .pc_src_o(pc_src), .ir_write_o(ir_write),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .iord_o(iord), .alu_src_a_o(alu_a),
        .alu_src_b_o(alu_b), .alu_op_o(alu_op), .reg_write_o(reg_write), .reg_dst_o(reg_dst),
        .mem_to_reg_o(mem_to_reg), .state_o(state), .illegal_o(illegal), .timeout_o(timeout),
        .instr_cnt_o(icnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write, mem_read, mem_write, iord, a;
        logic [1:0] b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       illegal, timeout;
        logic [3:0] state, cnt;
    } obs_t;

    int checks = 0, errors = 0;
    int m_state = 0, m_wc = 0, m_cnt = 0, m_raw = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: outputs and successor for one cycle, straight from the state table.
    function automatic void model(input int s, input logic [5:0] o, input logic [5:0] fn,
                                  input logic z, input logic r, input int wc,
                                  output obs_t e, output int nx, output bit ret);
        e = '0; nx = s; ret = 0;
        if ((s == 0 || s == 3 || s == 5) && wc >= TO) begin
            e.timeout = 1; nx = 0; return;
        end
        case (s)
            0:  begin e.mem_read = 1; e.b = 1; if (r) begin e.ir_write = 1; e.pc_write = 1; nx = 1; end end
            1:  begin
                    e.b = 3;
                    if (o == 0) nx = (fn == 8) ? 12 : 6;
                    else if (o == 4) nx = 10;
                    else if (o == 8 || o == 10) nx = 8;
                    else if (o == 35 || o == 43) nx = 2;
                    else if (o == 2 || o == 3) nx = 11;
                    else begin e.illegal = 1; nx = 0; end
                end
            2:  begin e.a = 1; e.b = 2; nx = (o == 35) ? 3 : 5; end
            3:  begin e.mem_read = 1; e.iord = 1; if (r) nx = 4; end
            4:  begin e.reg_write = 1; e.mem_to_reg = 1; nx = 0; ret = 1; end
            5:  begin e.mem_write = 1; e.iord = 1; if (r) begin nx = 0; ret = 1; end end
            6:  begin e.a = 1; e.alu_op = 2; nx = 7; end
            7:  begin e.reg_write = 1; e.reg_dst = 1; nx = 0; ret = 1; end
            8:  begin e.a = 1; e.b = 2; e.alu_op = (o == 10) ? 4 : 3; nx = 9; end
            9:  begin e.reg_write = 1; nx = 0; ret = 1; end
            10: begin e.a = 1; e.alu_op = 1; e.pc_src = 1; e.pc_write = z; nx = 0; ret = 1; end
            11: begin
                    e.pc_write = 1; e.pc_src = 2;
                    if (o == 3) begin e.reg_write = 1; e.reg_dst = 2; e.mem_to_reg = 2; end
                    nx = 0; ret = 1;
                end
            12: begin e.pc_write = 1; e.pc_src = 3; nx = 0; ret = 1; end
            default: nx = 0;
        endcase
    endfunction

    // Per-cycle compare at the falling edge; the model advances only when out of reset.
    initial begin
        obs_t e, g;
        int nx;
        bit ret;
        forever begin
            @(negedge clk);
            if (rst) begin m_state = 0; m_wc = 0; m_cnt = 0; m_raw = 0; end
            model(m_state, op, funct, zero, ready, m_wc, e, nx, ret);
            e.state = 4'(m_state);
            e.cnt   = 4'(m_cnt);
            g = '{pc_write, pc_src, ir_write, mem_read, mem_write, iord, alu_a, alu_b, alu_op,
                  reg_write, reg_dst, mem_to_reg, illegal, timeout, state, icnt};
            chk("cycle", 32'(g), 32'(e));
            if (!rst) begin
                m_wc = (nx == m_state && (m_state == 0 || m_state == 3 || m_state == 5) && !e.timeout)
                       ? m_wc + 1 : 0;
                if (ret) begin m_raw++; if (m_cnt < 15) m_cnt++; end
                m_state = nx;
            end
        end
    end

    task automatic cyc(input logic r, input logic z, input logic [3:0] es);
        @(posedge clk); #1;
        ready = r; zero = z;
        #3;
        chk("state", 32'(state), 32'(es));
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [10] = '{6'd0, 6'd0, 6'd4, 6'd8, 6'd10, 6'd35, 6'd43, 6'd2, 6'd3, 6'd63};
        int k = $urandom_range(0, 10);
        return (k == 10) ? 6'($urandom) : tbl[k];
    endfunction

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_cnt", 32'(icnt), 0);
        chk("rst_fetch", 32'({mem_read, alu_b, ir_write, illegal, timeout}), 32'b1_01_000);
        rst = 1'b0;

        // addi
        op = 6'd8;
        cyc(1, 0, 0); cyc(0, 0, 1); cyc(0, 0, 8); cyc(0, 0, 9);
        chk("addi_wb", 32'({reg_write, reg_dst, mem_to_reg}), 32'b1_00_00);
        cyc(0, 0, 0); chk("addi_cnt", 32'(icnt), 1);

        // lw, two wait cycles in MEM_RD
        op = 6'd35;
        cyc(1, 0, 0); cyc(0, 0, 1); cyc(0, 0, 2); cyc(0, 0, 3); cyc(0, 0, 3); cyc(1, 0, 3);
        cyc(0, 0, 4); chk("lw_m2r", 32'(mem_to_reg), 1);
        cyc(0, 0, 0); chk("lw_cnt", 32'(icnt), 2);

        // beq taken then not taken
        op = 6'd4;
        cyc(1, 0, 0); cyc(0, 0, 1); cyc(0, 1, 10);
        chk("beq_taken", 32'({pc_write, pc_src}), 32'b1_01);
        cyc(1, 0, 0); cyc(0, 0, 1); cyc(0, 0, 10);
        chk("beq_not", 32'({pc_write, pc_src}), 32'b0_01);
        cyc(0, 0, 0); chk("beq_cnt", 32'(icnt), 4);

        // jal then jr
        op = 6'd3;
        cyc(1, 0, 0); cyc(0, 0, 1); cyc(0, 0, 11);
        chk("jal", 32'({reg_write, reg_dst, mem_to_reg, pc_src}), 32'b1_10_10_10);
        op = 6'd0; funct = 6'd8;
        cyc(1, 0, 0); cyc(0, 0, 1); cyc(0, 0, 12);
        chk("jr", 32'({pc_write, pc_src}), 32'b1_11);
        cyc(0, 0, 0); chk("jr_cnt", 32'(icnt), 6);

        // illegal opcode
        op = 6'd63;
        cyc(1, 0, 0); cyc(0, 0, 1); chk("illegal_hi", 32'(illegal), 1);
        cyc(0, 0, 0); chk("illegal_lo", 32'(illegal), 0); chk("illegal_cnt", 32'(icnt), 6);

        // fetch timeout: three idle waits, then the abort pulse
        cyc(0, 0, 0); chk("to_wait1", 32'(timeout), 0);
        cyc(0, 0, 0); chk("to_wait2", 32'(timeout), 0);
        cyc(0, 0, 0); chk("to_pulse", 32'({timeout, mem_read}), 32'b10);
        cyc(0, 0, 0); chk("to_clear", 32'({timeout, mem_read}), 32'b01);

        // reset asynchronously in the middle of MEM_RD
        op = 6'd35;
        cyc(1, 0, 0); cyc(0, 0, 1); cyc(0, 0, 2); cyc(0, 0, 3);
        #2 rst = 1'b1;
        #1;
        chk("async_state", 32'(state), 0);
        chk("async_cnt", 32'(icnt), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 499) == 0);
            if (m_state == 0) begin
                op    = pick_op();
                funct = ($urandom_range(0, 1) == 0) ? 6'd8 : 6'($urandom);
            end
            zero  = 1'($urandom);
            ready = ($urandom_range(0, 9) < 6);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        chk("sat_cnt", 32'(icnt), (m_raw >= 15) ? 32'd15 : 32'(m_raw));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
